// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the response-owner encoding and the default bus widths used by
// mem_arbiter and its starvation-guard sub-module.
package mem_arb_pkg;

  // Default memory word-address and data widths.
  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 32;
  // Default number of back-to-back contested data grants before fetch is forced.
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Which requester owns the read data returning from memory next cycle.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DATA   = 2'd2
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_starve.sv
// Starvation guard for the fetch port of mem_arbiter.
// Counts consecutive cycles in which data was granted while fetch was also
// requesting, saturating at STARVE_MAX. When the count is at STARVE_MAX the
// force-fetch output tells the arbiter to let fetch through on contention.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   i_req          fetch request
//   i_gnt          fetch granted this cycle
//   d_gnt          data granted this cycle
//   force_fetch_c  combinational: fetch must win any contention this cycle
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_fetch_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  // Next count: clear when fetch is idle or served, else bump on a contested data grant.
  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Fetch wins once the data port has had its full run of contested grants.
  assign force_fetch_c = (starve_q == CNT_W'(STARVE_MAX));

endmodule : mem_arb_starve

// File: rtl/mem_arbiter.sv
// Two-port to one-port arbiter for the unified instruction/data memory.
// Each cycle at most one of the fetch and load/store ports is granted and its
// command is forwarded to memory in the same cycle. A one-entry owner register
// remembers whose read is in flight so the 1-cycle-latency read data can be
// flagged valid on the right port. Data normally has priority over fetch.
//
// Build option:
//   MEM_ARB_STARVE_GUARD_EN  when defined, a saturating counter forces a fetch
//                            grant after STARVE_MAX consecutive contested data
//                            grants; when undefined, data strictly wins.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_req/i_addr              fetch request and word address
//   i_gnt                     fetch granted (combinational)
//   i_rvalid/i_rdata          fetch read response
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb           load/store request and command
//   d_gnt                     data granted (combinational)
//   d_rvalid/d_rdata          load read response
//   m_en/m_we/m_addr/
//   m_wdata/m_wstrb           memory command (combinational)
//   m_rdata                   memory read data, valid the cycle after a read
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata
);

  owner_e owner_q;
  owner_e owner_d;
  logic   force_fetch_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Fetch starvation guard.
  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_gnt         (i_gnt),
    .d_gnt         (d_gnt),
    .force_fetch_c (force_fetch_c)
  );
`else
  // Strict data-over-fetch priority; the threshold has no effect here.
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign force_fetch_c     = 1'b0;
`endif

  // Grant selection, memory command mux and next response owner.
  // Everything is held at zero while rst is high.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    owner_d = OWN_NONE;
    if (!rst) begin
      if (i_req && (!d_req || force_fetch_c)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end

      if (i_gnt) begin
        m_en    = 1'b1;
        m_addr  = i_addr;
        owner_d = OWN_IFETCH;
      end else if (d_gnt) begin
        m_en    = 1'b1;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wstrb = d_wstrb;
        // Stores finish at grant; only loads expect returning data.
        owner_d = d_we ? OWN_NONE : OWN_DATA;
      end
    end
  end

  // Response owner register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with rst drops a response that was in flight when reset arrived.
  assign i_rvalid = !rst && (owner_q == OWN_IFETCH);
  assign d_rvalid = !rst && (owner_q == OWN_DATA);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the single-cycle core. It shares the unified instruction/data memory (64K words, one access per cycle, 1-cycle read latency) between the instruction-fetch port and the load/store port. Each cycle it grants at most one requester and forwards that request's command to memory. It then routes the returned read data back to the requester that owns it. It sits between `core` and `memory`, so memory has exactly one master.

## Interface
Parameters:
- `ADDR_W`, 16, memory word-address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive contested data grants before fetch is forced through (guard only)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request, held with `i_addr` until `i_gnt`
- `i_addr`  in  ADDR_W  fetch word address
- `i_gnt`  out  1  fetch granted this cycle
- `i_rvalid`  out  1  fetch read data valid
- `i_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  load/store request, held with its command fields until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data word address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  store byte enables
- `d_gnt`  out  1  data granted this cycle
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  DATA_W  load data
- `m_en`  out  1  memory access enable
- `m_we`  out  1  memory write enable
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_wstrb`  out  DATA_W/8  memory byte enables
- `m_rdata`  in  DATA_W  memory read data, valid the cycle after a read-enable

## Operation
- Grant logic is combinational from `req` inputs and registered state. `i_gnt` and `d_gnt` are never high together.
- Only one request → grant it. Both requests → grant data, unless the starvation guard forces fetch.
- Granted command drives `m_*` the same cycle: `m_en = i_gnt | d_gnt`. A fetch grant drives `m_we=0` and `m_wstrb=0`. When idle, `m_*` are all 0.
- Response owner register `owner` ∈ {NONE, IFETCH, DATA}. Next value:
  - IFETCH on a fetch grant
  - DATA on a load grant
  - NONE otherwise, including a store grant
- `i_rvalid = (owner==IFETCH)`, `d_rvalid = (owner==DATA)`.
- `i_rdata` and `d_rdata` both equal `m_rdata`; they are meaningful only while the matching rvalid is high.
- Stores complete at grant and produce no rvalid.
- Fully pipelined: a new grant may issue every cycle, including the cycle a response returns.

## Timing
- Reset values:
  - `owner=NONE`, starve counter 0.
  - While `rst` is high, every grant, rvalid and `m_en`/`m_we`/`m_wstrb` output is 0.
  - `m_addr`/`m_wdata` = 0 during reset.
- Grant latency: 0 cycles from `req` when uncontested.
- Read latency: rvalid is high exactly one cycle after the grant, for one cycle.
- Reset mid-operation: an outstanding response is dropped, and no rvalid is produced the cycle after `rst` deasserts.
- Requester dropping `req` before grant: request withdrawn, no side effects.
- Simultaneous `req` and a returning response on the same port: legal. The response (from the earlier grant) and the new grant both occur.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - Counter `starve` increments on each cycle with `d_gnt & i_req`, saturating at `STARVE_MAX`.
  - At `STARVE_MAX` under contention, fetch wins and `starve` clears.
  - `starve` also clears whenever `i_req` is low or fetch is granted.
- Not defined: strict data-over-fetch priority, no counter, and `STARVE_MAX` is unused.

## Structure
- Shared package `mem_arb_pkg`:
  - owner encoding `OWN_NONE=2'd0`, `OWN_IFETCH=2'd1`, `OWN_DATA=2'd2`
  - default `ADDR_W`/`DATA_W` constants
- One sub-module `mem_arb_starve`: saturating counter plus force-fetch output. It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`; otherwise the force-fetch output is tied 0.

## Test plan
- Reset: hold `rst` 2 cycles with both `req`s high → all grants, rvalid, `m_en` = 0. The first cycle after release grants data.
- Lone fetch:
  - `i_req`, `i_addr=16'h0010`, memory word `32'h00000513` → `i_gnt` same cycle, `m_addr=16'h0010`, `m_we=0`.
  - Next cycle `i_rvalid=1`, `i_rdata=32'h00000513`.
- Store then load, same address:
  - Store `d_addr=16'h0100`, `d_wdata=32'hDEADBEEF`, `d_wstrb=4'hF` → granted with no `d_rvalid`.
  - Load `16'h0100` next cycle → `d_rvalid` one cycle later with `32'hDEADBEEF`.
- Back-to-back contention: both `req` high 1 cycle → `d_gnt`. The next cycle grants the held fetch, and `d_rvalid` and `i_rvalid` arrive on consecutive cycles.
- Starvation, `STARVE_MAX=4`, guard on: `i_req` and `d_req` held high 10 cycles → grant pattern D,D,D,D,I,D,D,D,D,I. With the guard off: all D.
- Reset mid-read: assert `rst` the cycle after a load grant → `d_rvalid` stays 0, and `owner=NONE` after release.
